// File: rtl/df_mid_lsdc_alloc13.sv
// Entry allocator and valid tracker feeding the df_mid_lsdc_age13 age matrix.
// Grants the lowest free entries to up to ALLOC requests per cycle, all-or-nothing.
module df_mid_lsdc_alloc13 #(
  parameter int SIZE  = 8,
  parameter int ALLOC = 4,
  parameter int CNTW  = $clog2(SIZE + 1)
) (
  input  logic                         Clk,
  input  logic                         Reset_L,
  input  logic [ALLOC-1:0]             ReqVal,
  input  logic [SIZE-1:0]              DelValid,
  input  logic                         Flush,
  output logic                         ReqRdy,
  output logic [ALLOC-1:0][SIZE-1:0]   AllocIdx,
  output logic [ALLOC-1:0]             AllocVal,
  output logic [SIZE-1:0]              Valid,
  output logic [CNTW-1:0]              FreeCnt,
  output logic                         Full,
  output logic                         Empty,
  output logic                         ErrDelInvalid
);

  localparam int RCW = $clog2(ALLOC + 1);

  logic [SIZE-1:0]             valid_reg, valid_next;
  logic [CNTW-1:0]             free_cnt_reg, free_cnt_next;
  logic                        full_reg, empty_reg, err_reg;
  logic [RCW-1:0]              req_cnt;
  logic                        accept;
  logic [ALLOC-1:0][SIZE-1:0]  avail;
  logic [ALLOC-1:0][SIZE-1:0]  pick;
  logic [SIZE-1:0]             alloc_or;

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < ALLOC; i++) req_cnt = req_cnt + RCW'(ReqVal[i]);
  end

  assign accept = Reset_L & ~Flush & (32'(req_cnt) <= 32'(free_cnt_reg));
  assign ReqRdy = Reset_L & (accept | (req_cnt == '0));

  // Per-slot find-first chain: each requesting slot takes the lowest entry
  // still available after earlier slots have taken theirs.
  assign avail[0] = ~valid_reg;

  generate
    for (genvar gi = 0; gi < ALLOC; gi++) begin : g_slot
      assign pick[gi]     = ReqVal[gi] ? (avail[gi] & (~avail[gi] + SIZE'(1))) : '0;
      assign AllocIdx[gi] = accept ? pick[gi] : '0;
      assign AllocVal[gi] = accept & ReqVal[gi];
      if (gi < ALLOC - 1) begin : g_next
        assign avail[gi+1] = avail[gi] & ~pick[gi];
      end
    end
  endgenerate

  always_comb begin
    alloc_or = '0;
    for (int s = 0; s < ALLOC; s++) alloc_or = alloc_or | AllocIdx[s];
  end

  // Allocation is ORed after the delete mask, so a same-cycle delete of a
  // freshly granted entry cannot clear it.
  assign valid_next = Flush ? '0 : ((valid_reg & ~DelValid) | alloc_or);

  always_comb begin
    free_cnt_next = '0;
    for (int i = 0; i < SIZE; i++) free_cnt_next = free_cnt_next + CNTW'(~valid_next[i]);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      valid_reg    <= '0;
      free_cnt_reg <= CNTW'(SIZE);
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      err_reg      <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      free_cnt_reg <= free_cnt_next;
      full_reg     <= (free_cnt_next == '0);
      empty_reg    <= (free_cnt_next == CNTW'(SIZE));
      if (|(DelValid & ~valid_reg)) err_reg <= 1'b1;
    end
  end

  assign Valid         = valid_reg;
  assign FreeCnt       = free_cnt_reg;
  assign Full          = full_reg;
  assign Empty         = empty_reg;
  assign ErrDelInvalid = err_reg;

endmodule

// File: tb/tb_df_mid_lsdc_alloc13.sv
// Scoreboard bench for df_mid_lsdc_alloc13: stimulus queues hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_df_mid_lsdc_alloc13;

  logic             Clk = 1'b0;
  logic             Reset_L = 1'b0;
  logic [3:0]       ReqVal = 4'hF;
  logic [7:0]       DelValid = '0;
  logic             Flush = 1'b0;
  logic             ReqRdy;
  logic [3:0][7:0]  AllocIdx;
  logic [3:0]       AllocVal;
  logic [7:0]       Valid;
  logic [3:0]       FreeCnt;
  logic             Full, Empty, ErrDelInvalid;

  df_mid_lsdc_alloc13 dut (
    .Clk(Clk), .Reset_L(Reset_L), .ReqVal(ReqVal), .DelValid(DelValid), .Flush(Flush),
    .ReqRdy(ReqRdy), .AllocIdx(AllocIdx), .AllocVal(AllocVal), .Valid(Valid),
    .FreeCnt(FreeCnt), .Full(Full), .Empty(Empty), .ErrDelInvalid(ErrDelInvalid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic        rdy;
    logic [3:0]  aval;
    logic [31:0] idx;
    logic [7:0]  valid;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_txn   = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
  endtask

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] exp_free;
      e = sb.pop_front();
      exp_free = 4'($countones(~e.valid));
      $display("txn %0d req=%b del=%h fl=%b rst_l=%b rdy=%b aval=%b idx=%h valid=%h free=%0d err=%b",
               e.id, ReqVal, DelValid, Flush, Reset_L, ReqRdy, AllocVal, AllocIdx, Valid, FreeCnt, ErrDelInvalid);
      chk("ReqRdy",        e.id, 32'(ReqRdy),        32'(e.rdy));
      chk("AllocVal",      e.id, 32'(AllocVal),      32'(e.aval));
      chk("AllocIdx",      e.id, AllocIdx,           e.idx);
      chk("Valid",         e.id, 32'(Valid),         32'(e.valid));
      chk("FreeCnt",       e.id, 32'(FreeCnt),       32'(exp_free));
      chk("Full",          e.id, 32'(Full),          32'(exp_free == 4'd0));
      chk("Empty",         e.id, 32'(Empty),         32'(exp_free == 4'd8));
      chk("ErrDelInvalid", e.id, 32'(ErrDelInvalid), 32'(e.err));
    end
  end

  // Drive one cycle of inputs; expected valid/err are the registered values
  // visible during this cycle, the rest are combinational responses.
  task automatic cyc(input logic rst_l, input logic [3:0] req, input logic [7:0] del, input logic fl,
                     input logic e_rdy, input logic [3:0] e_aval, input logic [31:0] e_idx,
                     input logic [7:0] e_valid, input logic e_err);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset_L  = rst_l;
    ReqVal   = req;
    DelValid = del;
    Flush    = fl;
    e.id = n_txn; e.rdy = e_rdy; e.aval = e_aval; e.idx = e_idx; e.valid = e_valid; e.err = e_err;
    sb.push_back(e);
    n_txn++;
  endtask

  initial begin
    //   rst  req    del    fl  rdy  aval   idx {s3,s2,s1,s0}  valid  err
    cyc(0, 4'hF, 8'h00, 0, 0, 4'h0, 32'h00000000, 8'h00, 0);
    cyc(0, 4'hF, 8'h00, 0, 0, 4'h0, 32'h00000000, 8'h00, 0);
    cyc(1, 4'h3, 8'h00, 0, 1, 4'h3, 32'h00000201, 8'h00, 0);
    cyc(1, 4'hF, 8'h00, 0, 1, 4'hF, 32'h20100804, 8'h03, 0);
    cyc(1, 4'h3, 8'h00, 0, 1, 4'h3, 32'h00008040, 8'h3F, 0);
    cyc(1, 4'h0, 8'h5A, 0, 1, 4'h0, 32'h00000000, 8'hFF, 0);
    cyc(1, 4'hA, 8'h00, 0, 1, 4'hA, 32'h08000200, 8'hA5, 0);
    cyc(1, 4'h0, 8'h0A, 0, 1, 4'h0, 32'h00000000, 8'hAF, 0);
    cyc(1, 4'hF, 8'h00, 0, 1, 4'hF, 32'h40100802, 8'hA5, 0);
    cyc(1, 4'h1, 8'h01, 0, 0, 4'h0, 32'h00000000, 8'hFF, 0);
    cyc(1, 4'h3, 8'h02, 0, 0, 4'h0, 32'h00000000, 8'hFE, 0);
    cyc(1, 4'h3, 8'h00, 0, 1, 4'h3, 32'h00000201, 8'hFC, 0);
    cyc(1, 4'h0, 8'hF0, 0, 1, 4'h0, 32'h00000000, 8'hFF, 0);
    cyc(1, 4'h0, 8'h30, 0, 1, 4'h0, 32'h00000000, 8'h0F, 0);
    cyc(1, 4'h0, 8'h00, 0, 1, 4'h0, 32'h00000000, 8'h0F, 1);
    cyc(1, 4'hF, 8'h00, 0, 1, 4'hF, 32'h80402010, 8'h0F, 1);
    cyc(1, 4'h0, 8'h81, 0, 1, 4'h0, 32'h00000000, 8'hFF, 1);
    cyc(1, 4'h1, 8'h02, 1, 0, 4'h0, 32'h00000000, 8'h7E, 1);
    cyc(1, 4'h0, 8'h00, 0, 1, 4'h0, 32'h00000000, 8'h00, 1);
    cyc(1, 4'h5, 8'h00, 0, 1, 4'h5, 32'h00020001, 8'h00, 1);
    cyc(0, 4'hF, 8'h01, 0, 0, 4'h0, 32'h00000000, 8'h03, 1);
    cyc(1, 4'h1, 8'h01, 0, 1, 4'h1, 32'h00000001, 8'h00, 0);
    cyc(1, 4'h0, 8'h00, 0, 1, 4'h0, 32'h00000000, 8'h01, 1);
    cyc(0, 4'h0, 8'h00, 0, 0, 4'h0, 32'h00000000, 8'h01, 1);
    cyc(1, 4'h0, 8'h00, 0, 1, 4'h0, 32'h00000000, 8'h00, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
